ddr_cmd_queue: RTL
==================

Name: ddr_cmd_queue

Overview:
Downstream stage of the AXI4-Lite slave in the DDR controller path. Consumes the slave's single-beat wr_en/rd_en/add/data requests and buffers them in an in-order command FIFO. Issues each buffered request to the DDR memory-side command port with a valid/ready handshake. Returns read data to the slave through a response handshake.

Parameters:
ADDR_W, 32, request/command address width
DATA_W, 32, data width (fixed 4 byte lanes at default)
DEPTH, 8, command FIFO entries; must be a power of 2, at least 2
CNT_W, 4, width of q_count; equals log2(DEPTH)+1

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
req_wr_en  in  1  write request from AXI4-Lite slave
req_rd_en  in  1  read request from AXI4-Lite slave
req_add  in  ADDR_W  request byte address
req_wdata  in  DATA_W  write data
req_wstrb  in  4  byte-lane enables for writes
req_ready  out  1  queue can accept a request this cycle
rsp_valid  out  1  read response valid
rsp_ready  in  1  slave accepts read response
rsp_rdata  out  DATA_W  read data
rsp_err  out  1  response error flag, qualified by rsp_valid
mem_cmd_valid  out  1  command valid to DDR side
mem_cmd_ready  in  1  DDR side accepts command
mem_cmd_we  out  1  1 = write, 0 = read
mem_cmd_add  out  ADDR_W  word-aligned address (bits [1:0] forced to 0)
mem_cmd_wdata  out  DATA_W  write data
mem_cmd_wstrb  out  4  byte enables
mem_rd_valid  in  1  read data return strobe from DDR side
mem_rd_data  in  DATA_W  read return data
q_count  out  CNT_W  current FIFO occupancy
err_sticky  out  1  sticky protocol error

Behaviour:
- Reset values (async assert, sync release): req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_cmd_valid=0, mem_cmd_we=0, mem_cmd_add=0, mem_cmd_wdata=0, mem_cmd_wstrb=0, q_count=0, err_sticky=0. FIFO pointers are cleared; FIFO storage is not reset. FSM resets to IDLE.
- Enqueue: when (req_wr_en | req_rd_en) & req_ready, push {we, add, wdata, wstrb} on that edge.
- If req_wr_en and req_rd_en are both high: push only the write, and set err_sticky.
- A read entry stores wstrb=0. A write with wstrb=0 is pushed and issued unchanged.
- req_ready = (q_count != DEPTH). It is combinational from the count register.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo DEPTH.
- Enqueue while full: dropped, err_sticky set.
- Unaligned req_add (bits [1:0] != 0): enqueued with the address aligned, err_sticky set.
- FSM states:
  - IDLE: if FIFO not empty, load the head into the mem_cmd_* registers, set mem_cmd_valid=1, go to ISSUE.
  - ISSUE: hold mem_cmd_* stable until mem_cmd_valid & mem_cmd_ready. On that edge: pop the FIFO, drop mem_cmd_valid, go to IDLE if write or WAIT_RD if read.
  - WAIT_RD: on mem_rd_valid, capture mem_rd_data into rsp_rdata, set rsp_valid=1, rsp_err=0, go to RSP. mem_rd_valid in any other state is ignored and sets err_sticky.
  - RSP: hold rsp_* until rsp_ready. On the handshake edge drop rsp_valid and go to IDLE.
- Strict in-order processing. One read is outstanding at a time; writes behind a read wait.
- Minimum latency, push to mem_cmd_valid: 2 cycles (push edge, then IDLE load edge). A write with mem_cmd_ready held high takes 1 further cycle.
- Reset mid-operation: all in-flight commands and queued entries are discarded. No response is produced.
- err_sticky clears only on reset.

Optional Feature:
DDR_CMDQ_RD_TIMEOUT_EN:
- Defined: an 8-bit counter runs in WAIT_RD. It clears on entry and increments each cycle without mem_rd_valid. When it reaches 255: rsp_rdata=32'hDEADBEEF, rsp_err=1, rsp_valid=1, err_sticky set, go to RSP. A late mem_rd_valid after this is treated as stray (err_sticky).
- Undefined: no counter; WAIT_RD waits indefinitely; rsp_err is tied to 0.

Test Plan:
1. Reset, then a write (add=0x10, wdata=0xA5A5_1234, wstrb=4'hF) with mem_cmd_ready=1 -> mem_cmd_valid 2 cycles after push, carrying we=1, add=0x10, same data; q_count returns to 0; rsp_valid stays 0.
2. Read add=0x20; DDR returns 0xCAFE_F00D 5 cycles after accept; rsp_ready low for 3 cycles -> rsp_rdata=0xCAFEF00D, rsp_err=0; rsp_valid held 4 cycles, then drops.
3. mem_cmd_ready=0, push 9 writes back-to-back -> req_ready=0 after the 8th push, q_count=8; 9th dropped; err_sticky=1. Release ready -> 8 commands issued in order.
4. Same-cycle push and pop at q_count=3 -> q_count stays 3. Run 20 mixed ops across pointer wrap -> order preserved.
5. req_wr_en=req_rd_en=1, add=0x33 -> single write issued with mem_cmd_add=0x30; err_sticky=1.
6. With DDR_CMDQ_RD_TIMEOUT_EN, read with no mem_rd_valid -> after 255 cycles rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=1. ARESETN pulsed while in ISSUE -> all outputs at reset values, q_count=0.

Source files
------------

// File: rtl/ddr_cmd_queue_if.sv
// Memory-side command/read-return bundle between ddr_cmd_queue (master) and the DDR side (slave).
interface ddr_cmd_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [ADDR_W-1:0] mem_cmd_add;
    logic [DATA_W-1:0] mem_cmd_wdata;
    logic [3:0]        mem_cmd_wstrb;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_cmd_valid, mem_cmd_we, mem_cmd_add, mem_cmd_wdata, mem_cmd_wstrb,
        input  mem_cmd_ready, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_add, mem_cmd_wdata, mem_cmd_wstrb,
        output mem_cmd_ready, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/ddr_cmd_queue.sv
// In-order command FIFO between the AXI4-Lite slave and the DDR command port, one read outstanding.
// Optional build macro DDR_CMDQ_RD_TIMEOUT_EN adds a 255-cycle read-return timeout.
//
// state   | meaning
// IDLE    | waiting for a queued entry; loads head into mem_cmd_* when non-empty
// ISSUE   | mem_cmd_valid high, command held until mem_cmd_ready
// WAIT_RD | read issued, waiting for mem_rd_valid (or timeout when enabled)
// RSP     | read response presented, held until rsp_ready
module ddr_cmd_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              req_wr_en,
    input  logic              req_rd_en,
    input  logic [ADDR_W-1:0] req_add,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  q_count,
    output logic              err_sticky,
    ddr_cmd_queue_if.master   mem
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RSP} state_t;
    state_t state;

    logic              f_we    [DEPTH];
    logic [ADDR_W-1:0] f_add   [DEPTH];
    logic [DATA_W-1:0] f_wdata [DEPTH];
    logic [3:0]        f_wstrb [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic req_any, push, pop, req_err, stray_rd, to_fire;

    assign req_any   = req_wr_en | req_rd_en;
    assign req_ready = (q_count != CNT_W'(DEPTH));
    assign push      = req_any & req_ready;
    assign pop       = (state == ISSUE) & mem.mem_cmd_valid & mem.mem_cmd_ready;
    assign req_err   = req_any & ((req_wr_en & req_rd_en) | ~req_ready | (req_add[1:0] != 2'b00));
    assign stray_rd  = mem.mem_rd_valid & (state != WAIT_RD);

`ifdef DDR_CMDQ_RD_TIMEOUT_EN
    logic [7:0] to_cnt;
    assign to_fire = (state == WAIT_RD) & ~mem.mem_rd_valid & (to_cnt == 8'hFF);
`else
    assign to_fire = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge ACLK) begin
        if (push) begin
            f_we[wr_ptr]    <= req_wr_en;
            f_add[wr_ptr]   <= {req_add[ADDR_W-1:2], 2'b00};
            f_wdata[wr_ptr] <= req_wdata;
            f_wstrb[wr_ptr] <= req_wr_en ? req_wstrb : 4'h0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) err_sticky <= 1'b0;
        else if (req_err | stray_rd | to_fire) err_sticky <= 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state             <= IDLE;
            mem.mem_cmd_valid <= 1'b0;
            mem.mem_cmd_we    <= 1'b0;
            mem.mem_cmd_add   <= '0;
            mem.mem_cmd_wdata <= '0;
            mem.mem_cmd_wstrb <= 4'h0;
            rsp_valid         <= 1'b0;
            rsp_rdata         <= '0;
`ifdef DDR_CMDQ_RD_TIMEOUT_EN
            rsp_err           <= 1'b0;
            to_cnt            <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (q_count != '0) begin
                        mem.mem_cmd_valid <= 1'b1;
                        mem.mem_cmd_we    <= f_we[rd_ptr];
                        mem.mem_cmd_add   <= f_add[rd_ptr];
                        mem.mem_cmd_wdata <= f_wdata[rd_ptr];
                        mem.mem_cmd_wstrb <= f_wstrb[rd_ptr];
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem.mem_cmd_ready) begin
                        mem.mem_cmd_valid <= 1'b0;
                        state             <= mem.mem_cmd_we ? IDLE : WAIT_RD;
`ifdef DDR_CMDQ_RD_TIMEOUT_EN
                        to_cnt            <= 8'h00;
`endif
                    end
                end
                WAIT_RD: begin
                    if (mem.mem_rd_valid) begin
                        rsp_rdata <= mem.mem_rd_data;
                        rsp_valid <= 1'b1;
`ifdef DDR_CMDQ_RD_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= RSP;
                    end
`ifdef DDR_CMDQ_RD_TIMEOUT_EN
                    else if (to_fire) begin
                        rsp_rdata <= DATA_W'(32'hDEADBEEF);
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
